cp0_ctrl: RTL

//  Parametrised CP0 (system control coprocessor) for the MIPS core, successor to the fixed 6-IRQ CP0.

---
 rtl/cp0_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS system control coprocessor with clock-divided Count,
// sticky timer interrupt, exception/ERET commit and redirect PC.
module cp0_ctrl #(
  parameter int          HW_INT_NUM   = 6,
  parameter int          COUNT_DIV    = 2,
  parameter int          TIMER_IP7    = 1,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST   = 32'h0040_0000,
  parameter logic [31:0] STATUS_WMASK = 32'h0000_FF03,
  parameter logic [31:0] PRID_VAL     = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VAL   = 32'h0000_8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [4:0]            raddr_i,
  input  logic [31:0]           data_i,
  input  logic [HW_INT_NUM-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic                  eret_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  in_delayslot_i,
  input  logic [31:0]           bad_addr_i,
  output logic [31:0]           data_o,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           badvaddr_o,
  output logic                  timer_int_o,
  output logic                  int_req_o,
  output logic                  flush_o,
  output logic [31:0]           flush_pc_o
);

  localparam logic [4:0] A_BADV = 5'd8;
  localparam logic [4:0] A_CNT  = 5'd9;
  localparam logic [4:0] A_CMP  = 5'd11;
  localparam logic [4:0] A_STAT = 5'd12;
  localparam logic [4:0] A_CAUS = 5'd13;
  localparam logic [4:0] A_EPC  = 5'd14;
  localparam logic [4:0] A_PRID = 5'd15;
  localparam logic [4:0] A_CFG  = 5'd16;

  logic [31:0] count_q, compare_q, status_q, epc_q, badv_q;
  logic        phase_q, timer_q, bd_q;
  logic [4:0]  code_q;
  logic [1:0]  sw_ip_q;
  logic [5:0]  hw_ip_q;
  logic [5:0]  hw_next;
  logic        tick, mtc0, ip7, is_adr;

  assign hw_next = 6'(int_i);
  assign tick    = (COUNT_DIV == 1) ? 1'b1 : phase_q;
  // exception and ERET both swallow a same-cycle MTC0
  assign mtc0    = we_i & ~exc_valid_i & ~eret_i;
  assign ip7     = hw_ip_q[5] | ((TIMER_IP7 != 0) & timer_q);
  assign is_adr  = (exc_code_i == 5'd4) | (exc_code_i == 5'd5);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      compare_q <= '0;
      status_q  <= STATUS_RST;
      epc_q     <= '0;
      badv_q    <= '0;
      phase_q   <= 1'b0;
      timer_q   <= 1'b0;
      bd_q      <= 1'b0;
      code_q    <= '0;
      sw_ip_q   <= '0;
      hw_ip_q   <= '0;
    end else begin
      hw_ip_q <= hw_next;
      if (mtc0 && waddr_i == A_CNT) begin
        count_q <= data_i;
        phase_q <= 1'b0;
      end else begin
        if (tick) count_q <= count_q + 32'd1;
        phase_q <= (COUNT_DIV == 1) ? 1'b0 : ~phase_q;
      end
      if (mtc0 && waddr_i == A_CMP) begin
        compare_q <= data_i;
        timer_q   <= 1'b0;
      end else if (count_q == compare_q && compare_q != '0) begin
        timer_q <= 1'b1;
      end
      if (exc_valid_i) begin
        code_q      <= exc_code_i;
        status_q[1] <= 1'b1;
        if (!status_q[1]) begin
          epc_q <= in_delayslot_i ? exc_pc_i - 32'd4 : exc_pc_i;
          bd_q  <= in_delayslot_i;
        end
        if (is_adr) badv_q <= bad_addr_i;
      end else if (eret_i) begin
        status_q[1] <= 1'b0;
      end else if (mtc0) begin
        unique case (waddr_i)
          A_STAT:  status_q <= (status_q & ~STATUS_WMASK)
                             | (data_i & STATUS_WMASK);
          A_CAUS:  sw_ip_q  <= data_i[9:8];
          A_EPC:   epc_q    <= data_i;
          default: ;
        endcase
      end
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badv_q;
  assign timer_int_o = timer_q;
  assign cause_o     = {bd_q, timer_q, 14'd0, ip7, hw_ip_q[4:0],
                        sw_ip_q, 1'b0, code_q, 2'b00};

  assign int_req_o  = status_q[0] & ~status_q[1]
                    & |(cause_o[15:8] & status_q[15:8]);
  assign flush_o    = exc_valid_i | eret_i;
  assign flush_pc_o = exc_valid_i ? EXC_VECTOR :
                      eret_i      ? epc_q      : 32'd0;

  always_comb begin
    data_o = '0;
    unique case (raddr_i)
      A_BADV:  data_o = badv_q;
      A_CNT:   data_o = count_q;
      A_CMP:   data_o = compare_q;
      A_STAT:  data_o = status_q;
      A_CAUS:  data_o = cause_o;
      A_EPC:   data_o = epc_q;
      A_PRID:  data_o = PRID_VAL;
      A_CFG:   data_o = CONFIG_VAL;
      default: data_o = '0;
    endcase
  end

endmodule
